// File: rtl/cam_pkg.sv
// Shared camera-path definitions: FSM encoding, default geometry and pixel packing.
package cam_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StArm  = 2'd1,
        StFill = 2'd2,
        StDone = 2'd3
    } cam_state_t;

    localparam int unsigned DEF_H_RES  = 160;
    localparam int unsigned DEF_V_RES  = 120;
    localparam int unsigned DEF_ADDR_W = 15;

    // R lands in the top nibble so the VGA readout can split fields the same way.
    function automatic logic [11:0] rgb888_to_444(input logic [23:0] rgb);
        return {rgb[7:4], rgb[15:12], rgb[23:20]};
    endfunction

endpackage

// File: rtl/cam_edge_det.sv
// Registered rise/fall detector; one flop of history, edges flagged combinationally.
module cam_edge_det #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic sig_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= RESET_VAL;
        end else begin
            sig_q <= sig;
        end
    end

    assign rise = sig & ~sig_q;
    assign fall = ~sig & sig_q;

endmodule

// File: rtl/cam_fb_writer.sv
// Captures one camera frame as RGB444 into a frame-buffer BRAM in raster order.
module cam_fb_writer
    import cam_pkg::*;
#(
    parameter int unsigned H_RES  = DEF_H_RES,
    parameter int unsigned V_RES  = DEF_V_RES,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              p_clock,
    input  logic              rst,
    input  logic              start,
    input  logic              cont,
    input  logic              vsync,
    input  logic [23:0]       pixel_data,
    input  logic              pixel_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [11:0]       mem_data,
    output logic              mem_we,
    output logic              busy,
    output logic              done,
    output logic              short_frame,
    output logic              overrun,
    output logic [ADDR_W:0]   pix_count
);

    localparam int unsigned   FRAME_PIX_I = H_RES * V_RES;
    localparam logic [ADDR_W:0] FRAME_PIX = FRAME_PIX_I[ADDR_W:0];

    cam_state_t state;
    logic       vs_rise;
    logic       vs_fall;
    logic       room;
    logic       pix_inc;
    logic [ADDR_W:0] pix_next;

    // Reset history of 1 means a camera already in active video is not mistaken for a new frame.
    cam_edge_det #(
        .RESET_VAL (1'b1)
    ) u_vsync_edge (
        .clk  (p_clock),
        .rst  (rst),
        .sig  (vsync),
        .rise (vs_rise),
        .fall (vs_fall)
    );

    assign room     = pix_count < FRAME_PIX;
    assign pix_inc  = pixel_valid && room;
    assign pix_next = pix_count + {{ADDR_W{1'b0}}, pix_inc};

    always_ff @(posedge p_clock or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            mem_addr    <= '0;
            mem_data    <= '0;
            mem_we      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            short_frame <= 1'b0;
            overrun     <= 1'b0;
            pix_count   <= '0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start || cont) begin
                        state       <= StArm;
                        busy        <= 1'b1;
                        pix_count   <= '0;
                        short_frame <= 1'b0;
                        overrun     <= 1'b0;
                    end
                end
                StArm: begin
                    if (vs_fall) begin
                        state <= StFill;
                    end
                end
                StFill: begin
                    if (pix_inc) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= pix_count[ADDR_W-1:0];
                        mem_data  <= rgb888_to_444(pixel_data);
                        pix_count <= pix_next;
                    end else if (pixel_valid) begin
                        overrun <= 1'b1;
                    end
                    // A pixel coincident with the rise still counts toward completeness.
                    if (vs_rise) begin
                        state <= StDone;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        if (pix_next < FRAME_PIX) begin
                            short_frame <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    if (cont) begin
                        state       <= StArm;
                        busy        <= 1'b1;
                        pix_count   <= '0;
                        short_frame <= 1'b0;
                        overrun     <= 1'b0;
                    end else begin
                        state <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cam_fb_writer.sv
// Randomized frame-capture bench for cam_fb_writer on a 4x2 frame.
module tb_cam_fb_writer;

    localparam int unsigned H    = 4;
    localparam int unsigned V    = 2;
    localparam int unsigned AW   = 3;
    localparam int          NPIX = H * V;

    logic          p_clock = 1'b0;
    logic          rst;
    logic          start;
    logic          cont;
    logic          vsync;
    logic [23:0]   pixel_data;
    logic          pixel_valid;
    logic [AW-1:0] mem_addr;
    logic [11:0]   mem_data;
    logic          mem_we;
    logic          busy;
    logic          done;
    logic          short_frame;
    logic          overrun;
    logic [AW:0]   pix_count;

    int total = 0;
    int bad   = 0;

    logic [AW-1:0] wr_addr[$];
    logic [11:0]   wr_data[$];
    logic [23:0]   sent[$];
    logic          snap_short[$];
    logic          snap_over[$];
    int            snap_cnt[$];
    int            done_cnt;

    cam_fb_writer #(
        .H_RES  (H),
        .V_RES  (V),
        .ADDR_W (AW)
    ) dut (
        .p_clock     (p_clock),
        .rst         (rst),
        .start       (start),
        .cont        (cont),
        .vsync       (vsync),
        .pixel_data  (pixel_data),
        .pixel_valid (pixel_valid),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_we      (mem_we),
        .busy        (busy),
        .done        (done),
        .short_frame (short_frame),
        .overrun     (overrun),
        .pix_count   (pix_count)
    );

    always #5 p_clock = ~p_clock;

    always @(negedge p_clock) begin
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_data);
        end
        if (done) begin
            done_cnt++;
            snap_short.push_back(short_frame);
            snap_over.push_back(overrun);
            snap_cnt.push_back(int'(pix_count));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // Reference packing: red nibble high, then green, then blue.
    function automatic logic [11:0] model_444(input logic [23:0] p);
        int r, g, b;
        r = (int'(p) / 16) % 16;
        g = (int'(p) / 4096) % 16;
        b = (int'(p) / 1048576) % 16;
        return 12'(r * 256 + g * 16 + b);
    endfunction

    function automatic int min_frame(input int n);
        return (n < NPIX) ? n : NPIX;
    endfunction

    task automatic tick();
        @(posedge p_clock);
        #1;
    endtask

    task automatic clear_mon();
        wr_addr.delete();
        wr_data.delete();
        sent.delete();
        snap_short.delete();
        snap_over.delete();
        snap_cnt.delete();
        done_cnt = 0;
    endtask

    // Blanking, falling edge with a junk pixel, n pixels with random gaps, then rising edge.
    task automatic drive_frame(input int n, input bit last_on_rise, input int drop_cont_at);
        logic [23:0] px;
        vsync       = 1'b1;
        pixel_valid = 1'b0;
        repeat (3) tick();
        vsync       = 1'b0;
        pixel_valid = 1'b1;
        pixel_data  = 24'($urandom);
        tick();
        pixel_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 2) == 0) tick();
            if (i == drop_cont_at) cont = 1'b0;
            px = 24'($urandom);
            sent.push_back(px);
            pixel_valid = 1'b1;
            pixel_data  = px;
            if (last_on_rise && i == n - 1) vsync = 1'b1;
            tick();
            pixel_valid = 1'b0;
        end
        if (!last_on_rise) begin
            vsync = 1'b1;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        cont = 1'b0;
        vsync = 1'b1;
        pixel_valid = 1'b0;
        pixel_data = '0;
        repeat (3) tick();
        total++; if (mem_addr !== '0) begin bad++; $display("FAIL reset_addr got=%0h exp=0", mem_addr); end
        total++; if (mem_data !== '0) begin bad++; $display("FAIL reset_data got=%0h exp=0", mem_data); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", mem_we); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (short_frame !== 1'b0) begin bad++; $display("FAIL reset_short got=%b exp=0", short_frame); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        total++; if (pix_count !== '0) begin bad++; $display("FAIL reset_count got=%0d exp=0", pix_count); end
        rst = 1'b0;
        repeat (2) tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", busy); end
    endtask

    // Start a single-shot capture of n pixels and check everything against the frame rules.
    task automatic test_single(input string tag, input int n, input bit last_on_rise);
        int m;
        clear_mon();
        start = 1'b1;
        tick();
        start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL %s_arm_busy got=%b exp=1", tag, busy); end
        total++; if (pix_count !== '0) begin bad++; $display("FAIL %s_arm_count got=%0d exp=0", tag, pix_count); end
        drive_frame(n, last_on_rise, -1);
        repeat (3) tick();
        m = min_frame(n);
        total++;
        if (wr_addr.size() != m) begin
            bad++; $display("FAIL %s_nwrites got=%0d exp=%0d", tag, wr_addr.size(), m);
        end
        for (int i = 0; i < m && i < wr_addr.size(); i++) begin
            total++;
            if (wr_addr[i] !== AW'(i) || wr_data[i] !== model_444(sent[i])) begin
                bad++;
                $display("FAIL %s_write%0d got=%0h/%03h exp=%0h/%03h", tag, i, wr_addr[i], wr_data[i],
                         i, model_444(sent[i]));
            end
        end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL %s_done got=%0d exp=1", tag, done_cnt); end
        total++; if (short_frame !== (n < NPIX)) begin bad++; $display("FAIL %s_short got=%b exp=%b", tag, short_frame, n < NPIX); end
        total++; if (overrun !== (n > NPIX)) begin bad++; $display("FAIL %s_overrun got=%b exp=%b", tag, overrun, n > NPIX); end
        total++; if (int'(pix_count) != m) begin bad++; $display("FAIL %s_count got=%0d exp=%0d", tag, pix_count, m); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s_idle_busy got=%b exp=0", tag, busy); end
    endtask

    task automatic test_latency();
        logic [23:0] px;
        clear_mon();
        start = 1'b1;
        tick();
        start = 1'b0;
        vsync = 1'b0;
        tick();
        px = 24'($urandom);
        pixel_valid = 1'b1;
        pixel_data = px;
        tick();
        pixel_valid = 1'b0;
        total++;
        if (mem_we !== 1'b1 || mem_addr !== '0 || mem_data !== model_444(px)) begin
            bad++;
            $display("FAIL latency got=%b/%0h/%03h exp=1/0/%03h", mem_we, mem_addr, mem_data, model_444(px));
        end
        tick();
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL latency_strobe got=%b exp=0", mem_we); end
        vsync = 1'b1;
        repeat (3) tick();
        total++; if (done_cnt != 1) begin bad++; $display("FAIL latency_done got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_mid_frame_start();
        vsync = 1'b0;
        repeat (2) tick();
        clear_mon();
        start = 1'b1;
        pixel_valid = 1'b1;
        pixel_data = 24'($urandom);
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pixel_data = 24'($urandom);
            tick();
        end
        pixel_valid = 1'b0;
        total++; if (wr_addr.size() != 0) begin bad++; $display("FAIL midstart_early got=%0d exp=0", wr_addr.size()); end
        drive_frame(NPIX, 1'b0, -1);
        repeat (3) tick();
        total++; if (wr_addr.size() != NPIX) begin bad++; $display("FAIL midstart_nwrites got=%0d exp=%0d", wr_addr.size(), NPIX); end
        for (int i = 0; i < NPIX && i < wr_addr.size(); i++) begin
            total++;
            if (wr_addr[i] !== AW'(i) || wr_data[i] !== model_444(sent[i])) begin
                bad++;
                $display("FAIL midstart_write%0d got=%0h/%03h exp=%0h/%03h", i, wr_addr[i], wr_data[i],
                         i, model_444(sent[i]));
            end
        end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL midstart_done got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_continuous();
        int lens[3];
        lens[0] = 3;
        lens[1] = NPIX + 2;
        lens[2] = NPIX;
        clear_mon();
        cont = 1'b1;
        tick();
        for (int f = 0; f < 3; f++) begin
            wr_addr.delete();
            wr_data.delete();
            sent.delete();
            drive_frame(lens[f], 1'b0, (f == 2) ? 4 : -1);
            tick();
            total++;
            if (snap_short.size() != f + 1) begin
                bad++; $display("FAIL cont_done%0d got=%0d exp=%0d", f, snap_short.size(), f + 1);
            end else begin
                total++;
                if (snap_short[f] !== (lens[f] < NPIX) || snap_over[f] !== (lens[f] > NPIX) ||
                    snap_cnt[f] != min_frame(lens[f])) begin
                    bad++;
                    $display("FAIL cont_flags%0d got=%b/%b/%0d exp=%b/%b/%0d", f, snap_short[f],
                             snap_over[f], snap_cnt[f], lens[f] < NPIX, lens[f] > NPIX,
                             min_frame(lens[f]));
                end
            end
            total++;
            if (wr_addr.size() != min_frame(lens[f])) begin
                bad++; $display("FAIL cont_nwrites%0d got=%0d exp=%0d", f, wr_addr.size(), min_frame(lens[f]));
            end
            for (int i = 0; i < min_frame(lens[f]) && i < wr_addr.size(); i++) begin
                total++;
                if (wr_addr[i] !== AW'(i) || wr_data[i] !== model_444(sent[i])) begin
                    bad++;
                    $display("FAIL cont_write%0d_%0d got=%0h/%03h exp=%0h/%03h", f, i, wr_addr[i],
                             wr_data[i], i, model_444(sent[i]));
                end
            end
            if (f < 2) begin
                total++;
                if (busy !== 1'b1 || short_frame !== 1'b0 || overrun !== 1'b0 || pix_count !== '0) begin
                    bad++;
                    $display("FAIL cont_rearm%0d got=%b/%b/%b/%0d exp=1/0/0/0", f, busy, short_frame,
                             overrun, pix_count);
                end
            end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL cont_idle got=%b exp=0", busy); end
        wr_addr.delete();
        drive_frame(NPIX, 1'b0, -1);
        repeat (3) tick();
        total++; if (wr_addr.size() != 0) begin bad++; $display("FAIL cont_after got=%0d exp=0", wr_addr.size()); end
        total++; if (done_cnt != 3) begin bad++; $display("FAIL cont_total_done got=%0d exp=3", done_cnt); end
    endtask

    task automatic test_reset_mid_fill();
        clear_mon();
        start = 1'b1;
        tick();
        start = 1'b0;
        vsync = 1'b1;
        repeat (2) tick();
        vsync = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            pixel_valid = 1'b1;
            pixel_data = 24'($urandom);
            tick();
        end
        pixel_data = 24'($urandom);
        total++; if (pix_count !== 4'd3) begin bad++; $display("FAIL rstfill_pre got=%0d exp=3", pix_count); end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({mem_addr, mem_data, mem_we, busy, done, short_frame, overrun, pix_count} !== '0) begin
            bad++;
            $display("FAIL rstfill_async got=%0h/%03h/%b/%b/%b/%b/%b/%0d exp=all zero", mem_addr,
                     mem_data, mem_we, busy, done, short_frame, overrun, pix_count);
        end
        wr_addr.delete();
        done_cnt = 0;
        tick();
        rst = 1'b0;
        repeat (3) begin
            pixel_data = 24'($urandom);
            tick();
        end
        pixel_valid = 1'b0;
        vsync = 1'b1;
        repeat (4) tick();
        total++; if (wr_addr.size() != 0) begin bad++; $display("FAIL rstfill_writes got=%0d exp=0", wr_addr.size()); end
        total++; if (done_cnt != 0) begin bad++; $display("FAIL rstfill_done got=%0d exp=0", done_cnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstfill_busy got=%b exp=0", busy); end
    endtask

    initial begin
        done_cnt = 0;
        test_reset();
        test_single("full", NPIX, 1'b0);
        test_single("short", 5, 1'b1);
        test_single("over", NPIX + 2, 1'b0);
        test_single("fullrise", NPIX, 1'b1);
        test_latency();
        test_mid_frame_start();
        test_continuous();
        test_reset_mid_fill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
